// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall sequencer.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 3;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StDrain  = 2'b01,
    StHalted = 2'b10
  } state_e;

  // Destination scoreboard entry shadowing one downstream stage.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  localparam sb_entry_t SbEmpty = '0;

  function automatic sb_entry_t make_entry(input logic             valid,
                                           input logic [REG_W-1:0] rd,
                                           input logic             is_load);
    sb_entry_t e;
    e.valid   = valid;
    e.rd      = rd;
    e.is_load = is_load;
    return e;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// One source register checked against one scoreboard entry.
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             src_used,
  input  sb_entry_t        entry,
  output logic             match
);

  // r0 is an ordinary register, so no zero-register exclusion here.
  assign match = src_used & entry.valid & (src == entry.rd);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: RAW detection, redirect, mem stall, HALT drain.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit          FWD_EN       = 1'b1,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             id_halt,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainInit = DrainW'(DRAIN_CYCLES - 1);

  state_e            state_q, state_d;
  sb_entry_t         ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              stall_inc;

  logic match_rs_ex, match_rt_ex, match_rs_mem, match_rt_mem;
  logic ex_hit, mem_hit, hazard;

  // The WB entry only tracks retirement; it never causes a hazard.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  hazard_cmp u_cmp_rs_ex (
    .src      (id_rs),
    .src_used (id_rs_used),
    .entry    (ex_q),
    .match    (match_rs_ex)
  );

  hazard_cmp u_cmp_rt_ex (
    .src      (id_rt),
    .src_used (id_rt_used),
    .entry    (ex_q),
    .match    (match_rt_ex)
  );

  hazard_cmp u_cmp_rs_mem (
    .src      (id_rs),
    .src_used (id_rs_used),
    .entry    (mem_q),
    .match    (match_rs_mem)
  );

  hazard_cmp u_cmp_rt_mem (
    .src      (id_rt),
    .src_used (id_rt_used),
    .entry    (mem_q),
    .match    (match_rt_mem)
  );

  assign ex_hit  = match_rs_ex | match_rt_ex;
  assign mem_hit = match_rs_mem | match_rt_mem;

  // With forwarding only a load in EX cannot be bypassed in time.
  assign hazard = id_valid & (FWD_EN ? (ex_hit & ex_q.is_load) : (ex_hit | mem_hit));

  // Next-state, scoreboard shift and pipeline enable/flush decode.
  always_comb begin
    state_d    = state_q;
    ex_d       = ex_q;
    mem_d      = mem_q;
    wb_d       = wb_q;
    drain_d    = drain_q;
    stall_inc  = 1'b0;
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_we    = 1'b0;
    idex_flush = 1'b0;
    exmem_we   = 1'b0;
    memwb_we   = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          stall_inc = 1'b1;
        end else if (ex_redirect) begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
          idex_we    = 1'b1;
          idex_flush = 1'b1;
          exmem_we   = 1'b1;
          memwb_we   = 1'b1;
          ex_d       = SbEmpty;
          mem_d      = ex_q;
          wb_d       = mem_q;
        end else if (hazard) begin
          stall_inc  = 1'b1;
          idex_we    = 1'b1;
          idex_flush = 1'b1;
          exmem_we   = 1'b1;
          memwb_we   = 1'b1;
          ex_d       = SbEmpty;
          mem_d      = ex_q;
          wb_d       = mem_q;
        end else if (id_valid && id_halt) begin
          // HALT moves into EX; the fetched instruction behind it is discarded.
          ifid_we    = 1'b1;
          ifid_flush = 1'b1;
          idex_we    = 1'b1;
          exmem_we   = 1'b1;
          memwb_we   = 1'b1;
          ex_d       = make_entry(id_wr_en, id_rd, id_is_load);
          mem_d      = ex_q;
          wb_d       = mem_q;
          drain_d    = DrainInit;
          state_d    = StDrain;
        end else begin
          pc_we    = 1'b1;
          ifid_we  = 1'b1;
          idex_we  = 1'b1;
          exmem_we = 1'b1;
          memwb_we = 1'b1;
          ex_d     = make_entry(id_valid & id_wr_en, id_rd, id_is_load);
          mem_d    = ex_q;
          wb_d     = mem_q;
        end
      end
      StDrain: begin
        // Front end frozen; redirects are ignored while draining.
        if (!mem_stall) begin
          idex_we  = 1'b1;
          exmem_we = 1'b1;
          memwb_we = 1'b1;
          ex_d     = SbEmpty;
          mem_d    = ex_q;
          wb_d     = mem_q;
          if (drain_q == '0) begin
            state_d = StHalted;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
      end
      StHalted: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    // Reset forces every control output low regardless of state.
    if (rst) begin
      stall_inc  = 1'b0;
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b0;
      idex_we    = 1'b0;
      idex_flush = 1'b0;
      exmem_we   = 1'b0;
      memwb_we   = 1'b0;
      halted     = 1'b0;
    end
  end

  // State, drain counter and scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      drain_q <= '0;
      ex_q    <= SbEmpty;
      mem_q   <= SbEmpty;
      wb_q    <= SbEmpty;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  // Saturating count of RUN cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_inc && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: one instance with forwarding, one without, sharing stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_halt;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       ex_redirect, mem_stall;

  logic        f_pc_we, f_ifid_we, f_ifid_flush, f_idex_we, f_idex_flush;
  logic        f_exmem_we, f_memwb_we, f_halted;
  logic [15:0] f_stall;
  logic        n_pc_we, n_ifid_we, n_ifid_flush, n_idex_we, n_idex_flush;
  logic        n_exmem_we, n_memwb_we, n_halted;
  logic [15:0] n_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .DRAIN_CYCLES(3), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .mem_stall(mem_stall), .pc_we(f_pc_we), .ifid_we(f_ifid_we), .ifid_flush(f_ifid_flush),
    .idex_we(f_idex_we), .idex_flush(f_idex_flush), .exmem_we(f_exmem_we),
    .memwb_we(f_memwb_we), .halted(f_halted), .stall_cycles(f_stall)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .DRAIN_CYCLES(3), .CNT_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .mem_stall(mem_stall), .pc_we(n_pc_we), .ifid_we(n_ifid_we), .ifid_flush(n_ifid_flush),
    .idex_we(n_idex_we), .idex_flush(n_idex_flush), .exmem_we(n_exmem_we),
    .memwb_we(n_memwb_we), .halted(n_halted), .stall_cycles(n_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    id_rd = 0; id_wr_en = 0; id_is_load = 0; id_halt = 0;
    ex_redirect = 0; mem_stall = 0;
  endtask

  task automatic drive_id(input logic v, input logic [2:0] rs, input logic rsu,
                          input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                          input logic wr, input logic ld, input logic hl);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_wr_en = wr; id_is_load = ld; id_halt = hl;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    idle_in();
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_in();
    #3;
    // Reset values
    chk("rst_pc_we", f_pc_we, 0);
    chk("rst_ifid_we", f_ifid_we, 0);
    chk("rst_idex_we", f_idex_we, 0);
    chk("rst_memwb_we", n_memwb_we, 0);
    chk("rst_halted", f_halted, 0);
    chk("rst_stall", f_stall, 0);
    tick();
    chk("rst_exmem_we_held", f_exmem_we, 0);
    tick();
    rst = 0;
    #2;
    chk("idle_pc_we", f_pc_we, 1);
    chk("idle_ifid_flush", f_ifid_flush, 0);

    // Load-use with forwarding: LD r3 <- r1, then ADD r4 <- r3, r5
    drive_id(1, 3'd1, 1, 3'd0, 0, 3'd3, 1, 1, 0);
    #2;
    chk("lu_ld_pc_we", f_pc_we, 1);
    tick();
    drive_id(1, 3'd3, 1, 3'd5, 1, 3'd4, 1, 0, 0);
    #2;
    chk("lu_pc_we", f_pc_we, 0);
    chk("lu_ifid_we", f_ifid_we, 0);
    chk("lu_idex_we", f_idex_we, 1);
    chk("lu_idex_flush", f_idex_flush, 1);
    chk("lu_exmem_we", f_exmem_we, 1);
    tick();
    #2;
    chk("lu_stall_cnt", f_stall, 1);
    chk("lu_next_pc_we", f_pc_we, 1);
    chk("lu_next_idex_flush", f_idex_flush, 0);
    tick();

    // RAW without forwarding: ADD r2, then reader of r2
    do_reset();
    drive_id(1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 0);
    #2;
    tick();
    drive_id(1, 3'd2, 1, 3'd6, 1, 3'd7, 1, 0, 0);
    #2;
    chk("raw_ex_pc_we", n_pc_we, 0);
    chk("raw_ex_idex_flush", n_idex_flush, 1);
    chk("raw_fwd_no_stall", f_pc_we, 1);
    tick();
    #2;
    chk("raw_mem_pc_we", n_pc_we, 0);
    tick();
    #2;
    chk("raw_done_pc_we", n_pc_we, 1);
    chk("raw_stall_cnt", n_stall, 2);
    tick();

    // Redirect squashes a load-use hazard
    do_reset();
    drive_id(1, 3'd1, 1, 3'd0, 0, 3'd3, 1, 1, 0);
    #2;
    tick();
    drive_id(1, 3'd3, 1, 3'd0, 0, 3'd4, 1, 0, 0);
    ex_redirect = 1;
    #2;
    chk("redir_pc_we", f_pc_we, 1);
    chk("redir_ifid_we", f_ifid_we, 1);
    chk("redir_ifid_flush", f_ifid_flush, 1);
    chk("redir_idex_flush", f_idex_flush, 1);
    tick();
    ex_redirect = 0;
    #2;
    chk("redir_ex_bubble", f_pc_we, 1);
    chk("redir_stall_cnt", f_stall, 0);
    chk("redir_ld_in_mem_nofwd", n_pc_we, 0);
    tick();

    // mem_stall holds a pending redirect for 4 cycles
    do_reset();
    mem_stall = 1;
    ex_redirect = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("ms_pc_we", f_pc_we, 0);
      chk("ms_idex_we", f_idex_we, 0);
      chk("ms_memwb_we", f_memwb_we, 0);
      chk("ms_ifid_flush", f_ifid_flush, 0);
      tick();
    end
    mem_stall = 0;
    #2;
    chk("ms_redir_ifid_flush", f_ifid_flush, 1);
    chk("ms_redir_idex_flush", f_idex_flush, 1);
    chk("ms_redir_pc_we", f_pc_we, 1);
    chk("ms_stall_cnt", f_stall, 4);
    tick();
    ex_redirect = 0;

    // HALT drain with two stall cycles in DRAIN
    do_reset();
    drive_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
    #2;
    chk("halt_pc_we", f_pc_we, 0);
    chk("halt_ifid_flush", f_ifid_flush, 1);
    chk("halt_idex_we", f_idex_we, 1);
    chk("halt_halted", f_halted, 0);
    tick();
    idle_in();
    ex_redirect = 1;
    #2;
    chk("drain_pc_we", f_pc_we, 0);
    chk("drain_ifid_we", f_ifid_we, 0);
    chk("drain_exmem_we", f_exmem_we, 1);
    chk("drain_redir_ignored", f_ifid_flush, 0);
    chk("drain_redir_idex_flush", f_idex_flush, 0);
    tick();
    ex_redirect = 0;
    mem_stall = 1;
    #2;
    chk("drain_ms_exmem_we", f_exmem_we, 0);
    tick();
    #2;
    tick();
    mem_stall = 0;
    #2;
    chk("drain_not_yet_1", f_halted, 0);
    tick();
    #2;
    chk("drain_not_yet_0", f_halted, 0);
    chk("drain_memwb_we", f_memwb_we, 1);
    tick();
    #2;
    chk("halted_set", f_halted, 1);
    chk("halted_pc_we", f_pc_we, 0);
    chk("halted_idex_we", f_idex_we, 0);
    chk("halted_memwb_we", f_memwb_we, 0);
    tick();
    #2;
    chk("halted_sticky", f_halted, 1);

    // Asynchronous reset in the middle of DRAIN
    do_reset();
    mem_stall = 1;
    #2;
    tick();
    mem_stall = 0;
    #2;
    chk("pre_rst_stall_cnt", f_stall, 1);
    drive_id(1, 3'd1, 1, 3'd0, 0, 3'd3, 1, 1, 0);
    tick();
    drive_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
    tick();
    idle_in();
    #2;
    chk("pre_rst_drain_pc_we", f_pc_we, 0);
    #1;
    rst = 1;
    #1;
    chk("arst_pc_we", f_pc_we, 0);
    chk("arst_idex_we", f_idex_we, 0);
    chk("arst_exmem_we", f_exmem_we, 0);
    chk("arst_memwb_we", n_memwb_we, 0);
    chk("arst_halted", f_halted, 0);
    chk("arst_stall_f", f_stall, 0);
    chk("arst_stall_n", n_stall, 0);
    tick();
    rst = 0;
    drive_id(1, 3'd3, 1, 3'd0, 0, 3'd4, 1, 0, 0);
    #2;
    chk("post_rst_sb_empty", n_pc_we, 1);
    chk("post_rst_run_pc_we", f_pc_we, 1);
    chk("post_rst_exmem_we", f_exmem_we, 1);
    tick();
    idle_in();
    #2;
    chk("post_rst_still_run", f_pc_we, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
